baccarat_round_ctrl: RTL

- Parametrised successor to the single-hand baccarat dealing FSM.
- Sequences complete baccarat rounds using a request/acknowledge handshake to the card source, which replaces free-running one-card-per-clock dealing.
- Applies full third-card rules, including naturals, and drives win lights.
- Keeps saturating per-outcome tallies and plays NUM_ROUNDS back-to-back rounds per start. Sits between the deck/card-register datapath and the display/score logic.

---
 rtl/baccarat_round_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/baccarat_round_ctrl.sv
// Multi-round baccarat dealing controller with a card request/acknowledge handshake.
// Build option: define BACCARAT_NATURAL_EN to end dealing on a natural (8/9) after two cards.
module baccarat_round_ctrl #(
    parameter int NUM_ROUNDS = 1,
    parameter int WIN_W      = 8
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             start,
    input  logic             deal_ack,
    input  logic [3:0]       pscore,
    input  logic [3:0]       dscore,
    input  logic [3:0]       pcard3,
    output logic             deal_req,
    output logic [2:0]       load_pcard,
    output logic [2:0]       load_dcard,
    output logic             player_win_light,
    output logic             dealer_win_light,
    output logic [WIN_W-1:0] player_wins,
    output logic [WIN_W-1:0] dealer_wins,
    output logic [WIN_W-1:0] ties,
    output logic             busy,
    output logic             round_done
);

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,  ST_P1   = 4'd1,  ST_D1   = 4'd2, ST_P2 = 4'd3,
        ST_D2   = 4'd4,  ST_DEC2 = 4'd5,  ST_P3   = 4'd6, ST_DEC3 = 4'd7,
        ST_D3   = 4'd8,  ST_EVAL = 4'd9,  ST_SHOW = 4'd10
    } state_t;

    localparam logic [7:0] ROUNDS_M1 = 8'(NUM_ROUNDS - 1);

    state_t           state_r;
    state_t           state_s;
    logic [7:0]       round_cnt_r;
    logic             player_light_r;
    logic             dealer_light_r;
    logic [WIN_W-1:0] player_wins_r;
    logic [WIN_W-1:0] dealer_wins_r;
    logic [WIN_W-1:0] ties_r;
    logic             natural_s;
    logic             deal_req_s;
    logic [2:0]       load_p_s;
    logic [2:0]       load_d_s;
    logic             busy_s;
    logic             round_done_s;

    // Dealer third-card table, indexed by dealer two-card score and player third card.
    function automatic logic dealer_draws(input logic [3:0] ds, input logic [3:0] p3);
        logic draw;
        case (ds)
            4'd0, 4'd1, 4'd2: draw = 1'b1;
            4'd3:             draw = (p3 != 4'd8);
            4'd4:             draw = (p3 >= 4'd2) && (p3 <= 4'd7);
            4'd5:             draw = (p3 >= 4'd4) && (p3 <= 4'd7);
            4'd6:             draw = (p3 >= 4'd6) && (p3 <= 4'd7);
            default:          draw = 1'b0;
        endcase
        return draw;
    endfunction

    function automatic logic [WIN_W-1:0] sat_inc(input logic [WIN_W-1:0] v);
        logic [WIN_W-1:0] r;
        if (v == {WIN_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + WIN_W'(1'b1);
        end
        return r;
    endfunction

`ifdef BACCARAT_NATURAL_EN
    assign natural_s = (pscore >= 4'd8) || (dscore >= 4'd8);
`else
    assign natural_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (resetb) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; dealing states wait on deal_ack.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: state_s = start    ? ST_P1   : ST_IDLE;
            ST_P1:   state_s = deal_ack ? ST_D1   : ST_P1;
            ST_D1:   state_s = deal_ack ? ST_P2   : ST_D1;
            ST_P2:   state_s = deal_ack ? ST_D2   : ST_P2;
            ST_D2:   state_s = deal_ack ? ST_DEC2 : ST_D2;
            ST_DEC2: begin
                if (natural_s) begin
                    state_s = ST_EVAL;
                end else if (pscore <= 4'd5) begin
                    state_s = ST_P3;
                end else if (dscore <= 4'd5) begin
                    state_s = ST_D3;
                end else begin
                    state_s = ST_EVAL;
                end
            end
            ST_P3:   state_s = deal_ack ? ST_DEC3 : ST_P3;
            ST_DEC3: state_s = dealer_draws(dscore, pcard3) ? ST_D3 : ST_EVAL;
            ST_D3:   state_s = deal_ack ? ST_EVAL : ST_D3;
            ST_EVAL: state_s = ST_SHOW;
            ST_SHOW: state_s = (round_cnt_r != 8'd0) ? ST_P1 : ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Outputs; strobes are gated by reset so nothing loads during the reset cycle.
    always_comb begin
        deal_req_s   = 1'b0;
        load_p_s     = 3'b000;
        load_d_s     = 3'b000;
        busy_s       = 1'b0;
        round_done_s = 1'b0;
        if (!resetb) begin
            busy_s = (state_r != ST_IDLE);
            case (state_r)
                ST_P1:   begin deal_req_s = 1'b1; load_p_s = {2'b00, deal_ack}; end
                ST_D1:   begin deal_req_s = 1'b1; load_d_s = {2'b00, deal_ack}; end
                ST_P2:   begin deal_req_s = 1'b1; load_p_s = {1'b0, deal_ack, 1'b0}; end
                ST_D2:   begin deal_req_s = 1'b1; load_d_s = {1'b0, deal_ack, 1'b0}; end
                ST_P3:   begin deal_req_s = 1'b1; load_p_s = {deal_ack, 2'b00}; end
                ST_D3:   begin deal_req_s = 1'b1; load_d_s = {deal_ack, 2'b00}; end
                ST_SHOW: round_done_s = (round_cnt_r == 8'd0);
                default: deal_req_s = 1'b0;
            endcase
        end else begin
            busy_s = 1'b0;
        end
    end

    // Round counter, win lights and saturating tallies.
    always_ff @(posedge clk) begin
        if (resetb) begin
            round_cnt_r    <= 8'd0;
            player_light_r <= 1'b0;
            dealer_light_r <= 1'b0;
            player_wins_r  <= '0;
            dealer_wins_r  <= '0;
            ties_r         <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        round_cnt_r    <= ROUNDS_M1;
                        player_light_r <= 1'b0;
                        dealer_light_r <= 1'b0;
                    end
                end
                ST_EVAL: begin
                    if (pscore > dscore) begin
                        player_light_r <= 1'b1;
                        player_wins_r  <= sat_inc(player_wins_r);
                    end else if (dscore > pscore) begin
                        dealer_light_r <= 1'b1;
                        dealer_wins_r  <= sat_inc(dealer_wins_r);
                    end else begin
                        player_light_r <= 1'b1;
                        dealer_light_r <= 1'b1;
                        ties_r         <= sat_inc(ties_r);
                    end
                end
                ST_SHOW: begin
                    if (round_cnt_r != 8'd0) begin
                        round_cnt_r    <= round_cnt_r - 8'd1;
                        player_light_r <= 1'b0;
                        dealer_light_r <= 1'b0;
                    end
                end
                default: round_cnt_r <= round_cnt_r;
            endcase
        end
    end

    assign deal_req         = deal_req_s;
    assign load_pcard       = load_p_s;
    assign load_dcard       = load_d_s;
    assign busy             = busy_s;
    assign round_done       = round_done_s;
    assign player_win_light = player_light_r;
    assign dealer_win_light = dealer_light_r;
    assign player_wins      = player_wins_r;
    assign dealer_wins      = dealer_wins_r;
    assign ties             = ties_r;

endmodule
